// File: rtl/mips_sb_pkg.sv
// Shared constants and types for the destination-register scoreboard.
// Address width, register count, the zero register and the in-flight total width.
package mips_sb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam int TOTAL_W    = 7;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/sb_reg_counter.sv
// Saturating up/down in-flight write counter for one architectural register.
// Simultaneous increment and decrement hold the count; clear wins over both.
module sb_reg_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Next count: clear, hold on coincident events, otherwise saturate at both ends.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = CNT_ZERO;
        end else if (inc && dec) begin
            count_next_s = count_r;
        end else if (inc && (count_r != CNT_MAX)) begin
            count_next_s = count_r + CNT_ONE;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: per-register in-flight write counters and decode stall.
// Optional SCOREBOARD_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue.
module dest_reg_scoreboard
    import mips_sb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [REG_ADDR_W-1:0] issue_dest_addr,
    input  logic [REG_ADDR_W-1:0] src_a_addr,
    input  logic [REG_ADDR_W-1:0] src_b_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest_addr,
    input  logic                  flush,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   pending_mask,
    output logic [TOTAL_W-1:0]    inflight_total,
    output logic                  wb_underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    logic [CNT_W-1:0]    cnt_s      [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next_s [NUM_REGS];
    logic                src_a_busy_s;
    logic                src_b_busy_s;
    logic                dest_full_s;
    logic                issue_go_s;
    logic [TOTAL_W-1:0]  total_next_s;
    logic [TOTAL_W-1:0]  total_r;
    logic                underflow_r;
    logic [NUM_REGS-1:0] pending_s;

    assign cnt_s[0]      = CNT_ZERO;
    assign cnt_next_s[0] = CNT_ZERO;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock      (clock),
            .reset      (reset),
            .clear      (flush),
            .inc        (issue_go_s && (issue_dest_addr == REG_ADDR_W'(g))),
            .dec        (wb_valid && (wb_dest_addr == REG_ADDR_W'(g))),
            .count      (cnt_s[g]),
            .count_next (cnt_next_s[g])
        );
    end

    // Source hazards; with bypass, a final pending write retiring now does not block.
    always_comb begin
        src_a_busy_s = (cnt_s[src_a_addr] != CNT_ZERO);
        src_b_busy_s = (cnt_s[src_b_addr] != CNT_ZERO);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && (wb_dest_addr == src_a_addr) && (cnt_s[src_a_addr] == CNT_ONE)) begin
            src_a_busy_s = 1'b0;
        end else begin
            src_a_busy_s = (cnt_s[src_a_addr] != CNT_ZERO);
        end
        if (wb_valid && (wb_dest_addr == src_b_addr) && (cnt_s[src_b_addr] == CNT_ONE)) begin
            src_b_busy_s = 1'b0;
        end else begin
            src_b_busy_s = (cnt_s[src_b_addr] != CNT_ZERO);
        end
`endif
    end

    // Saturation at the destination is enforced inside each counter so that a
    // coincident write-back to a full register still holds its count.
    assign dest_full_s = issue_writes && (cnt_s[issue_dest_addr] == CNT_MAX);
    assign stall       = issue_valid && (src_a_busy_s || src_b_busy_s || dest_full_s);
    assign issue_go_s  = issue_valid && issue_writes && !src_a_busy_s && !src_b_busy_s
                         && !flush && (issue_dest_addr != ZERO_REG);

    // Sum of post-edge counts, so the registered total tracks the counters exactly.
    always_comb begin
        total_next_s = 7'd0;
        for (int i = 0; i < NUM_REGS; i++) begin
            total_next_s = total_next_s + TOTAL_W'(cnt_next_s[i]);
        end
    end

    // Per-register pending flags; register 0 is never tracked.
    always_comb begin
        pending_s = {NUM_REGS{1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            pending_s[i] = (cnt_s[i] != CNT_ZERO);
        end
    end

    // In-flight total register.
    always_ff @(posedge clock) begin
        if (reset) begin
            total_r <= 7'd0;
        end else begin
            total_r <= total_next_s;
        end
    end

    // Sticky underflow flag; flush does not clear it.
    always_ff @(posedge clock) begin
        if (reset) begin
            underflow_r <= 1'b0;
        end else if (wb_valid && (wb_dest_addr != ZERO_REG) && (cnt_s[wb_dest_addr] == CNT_ZERO)) begin
            underflow_r <= 1'b1;
        end else begin
            underflow_r <= underflow_r;
        end
    end

    assign pending_mask   = pending_s;
    assign inflight_total = total_r;
    assign wb_underflow   = underflow_r;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard with a rule-level reference model and per-cycle compare.
// Build with SCOREBOARD_WB_BYPASS_EN defined to exercise the write-back bypass expectation.
module tb_dest_reg_scoreboard;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic        issue_writes;
    logic [4:0]  issue_dest_addr;
    logic [4:0]  src_a_addr;
    logic [4:0]  src_b_addr;
    logic        wb_valid;
    logic [4:0]  wb_dest_addr;
    logic        flush;
    logic        stall;
    logic [31:0] pending_mask;
    logic [6:0]  inflight_total;
    logic        wb_underflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    int m_cnt [32];
    bit m_uf;

    dest_reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_writes    (issue_writes),
        .issue_dest_addr (issue_dest_addr),
        .src_a_addr      (src_a_addr),
        .src_b_addr      (src_b_addr),
        .wb_valid        (wb_valid),
        .wb_dest_addr    (wb_dest_addr),
        .flush           (flush),
        .stall           (stall),
        .pending_mask    (pending_mask),
        .inflight_total  (inflight_total),
        .wb_underflow    (wb_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit src_busy(input int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && m_cnt[a] == 1 && wb_valid && int'(wb_dest_addr) == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_stall();
        return issue_valid && (src_busy(int'(src_a_addr)) || src_busy(int'(src_b_addr)) ||
               (issue_writes && issue_dest_addr != 5'd0 && m_cnt[issue_dest_addr] == MAXC));
    endfunction

    // Reference model: apply the scoreboard rules to plain integer counts.
    always @(posedge clock) begin
        if (reset) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_uf = 1'b0;
        end else begin
            bit issue_in;
            bit wb_in;
            int d;
            int w;
            d = int'(issue_dest_addr);
            w = int'(wb_dest_addr);
            wb_in = wb_valid && w != 0;
            if (wb_in && m_cnt[w] == 0) m_uf = 1'b1;
            if (flush) begin
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else begin
                issue_in = issue_valid && issue_writes && d != 0 &&
                           !src_busy(int'(src_a_addr)) && !src_busy(int'(src_b_addr));
                if (!(issue_in && wb_in && d == w)) begin
                    if (issue_in && m_cnt[d] < MAXC) m_cnt[d]++;
                    if (wb_in && m_cnt[w] > 0) m_cnt[w]--;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            logic [31:0] pm;
            int tot;
            pm  = 32'd0;
            tot = 0;
            for (int i = 1; i < 32; i++) begin
                if (m_cnt[i] != 0) pm[i] = 1'b1;
                tot += m_cnt[i];
            end
            check("cyc_stall", {31'd0, stall}, {31'd0, exp_stall()});
            check("cyc_pending", pending_mask, pm);
            check("cyc_total", {25'd0, inflight_total}, tot);
            check("cyc_underflow", {31'd0, wb_underflow}, {31'd0, m_uf});
        end
    end

    task automatic drive(input logic iv, input logic iw, input logic [4:0] d,
                         input logic [4:0] sa, input logic [4:0] sb,
                         input logic wv, input logic [4:0] wa, input logic fl);
        issue_valid = iv; issue_writes = iw; issue_dest_addr = d;
        src_a_addr = sa; src_b_addr = sb;
        wb_valid = wv; wb_dest_addr = wa; flush = fl;
        #3;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pending", pending_mask, 32'd0);
        check("rst_total", {25'd0, inflight_total}, 32'd0);
        check("rst_underflow", {31'd0, wb_underflow}, 32'd0);
        tick();

        // Write r5, then read it.
        drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r5_stall", {31'd0, stall}, 32'd1);
        check("r5_pending", pending_mask, 32'h0000_0020);
        check("r5_total", {25'd0, inflight_total}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 1'b0); tick();
        drive(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r5_wb_stall", {31'd0, stall}, 32'd0);
        check("r5_wb_total", {25'd0, inflight_total}, 32'd0);
        tick();

        // r0 is never tracked.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        end
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r0_stall", {31'd0, stall}, 32'd0);
        check("r0_pending", pending_mask, 32'd0);
        check("r0_total", {25'd0, inflight_total}, 32'd0);
        tick();

        // Saturate r7, then coincident issue and write-back.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        end
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r7_full_stall", {31'd0, stall}, 32'd1);
        check("r7_full_total", {25'd0, inflight_total}, 32'd3);
        tick();
        drive(1'b1, 1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0); tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r7_hold_total", {25'd0, inflight_total}, 32'd3);
        check("r7_hold_pending", pending_mask, 32'h0000_0080);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0); tick();
        end
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("r7_drain_total", {25'd0, inflight_total}, 32'd0);

        // Underflow is sticky through flush.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0); tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        check("uf_set", {31'd0, wb_underflow}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("uf_after_flush", {31'd0, wb_underflow}, 32'd1);

        // Flush beats a coincident issue.
        drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        check("fl_pre_total", {25'd0, inflight_total}, 32'd2);
        check("fl_pre_pending", pending_mask, 32'h0000_0018);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("fl_total", {25'd0, inflight_total}, 32'd0);
        check("fl_pending", pending_mask, 32'd0);
        tick();

        // Write-back bypass on a source with count 1.
        drive(1'b1, 1'b1, 5'd2, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd2, 1'b1, 5'd2, 1'b0);
        check("byp_stall", {31'd0, stall}, BYP ? 32'd0 : 32'd1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("byp_total", {25'd0, inflight_total}, 32'd0);

        // Mixed traffic, then reset overriding issue and flush.
        drive(1'b1, 1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b1, 1'b1, 5'd11, 5'd12, 5'd0, 1'b1, 5'd10, 1'b0); tick();
        drive(1'b1, 1'b1, 5'd12, 5'd11, 5'd13, 1'b0, 5'd0, 1'b0); tick();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("mix_pending", pending_mask, 32'h0000_0800);
        reset = 1'b1;
        drive(1'b1, 1'b1, 5'd14, 5'd0, 5'd0, 1'b1, 5'd15, 1'b1); tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        check("rst2_underflow", {31'd0, wb_underflow}, 32'd0);
        check("rst2_total", {25'd0, inflight_total}, 32'd0);
        check("rst2_pending", pending_mask, 32'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
